// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Sequences an external WIDTH-bit up/down counter. A command (target,
//   direction, mode, step-rate divider) is taken over a valid/ready handshake;
//   the block then issues single-cycle step strobes, paced by a prescaler,
//   until the live count reaches the target (one-shot) or until aborted
//   (repeat).
//
// Ports
//   i_clk          clock, all state updates on rising edge
//   i_rst          synchronous active-high reset
//   i_cmd_valid    command present
//   o_cmd_ready    command can be accepted (idle and not in reset)
//   i_cmd_target   count value to stop at / match on
//   i_cmd_up       1 = count up, 0 = count down
//   i_cmd_oneshot  1 = stop at target, 0 = repeat until abort
//   i_cmd_div      step every i_cmd_div+1 cycles
//   i_hold         pause: freezes prescaler, suppresses step/match
//   i_abort        terminate the active run
//   i_count        current counter value (reflects a step one cycle later)
//   o_step         counter step enable, one cycle per tick
//   o_up           latched direction to the counter
//   o_match        tick occurred with count == target
//   o_busy         a run is active
//   o_done         one-cycle pulse after one-shot completion
module counter_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [WIDTH-1:0] i_cmd_target,
  input  logic             i_cmd_up,
  input  logic             i_cmd_oneshot,
  input  logic [DIV_W-1:0] i_cmd_div,
  input  logic             i_hold,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_count,
  output logic             o_step,
  output logic             o_up,
  output logic             o_match,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_target;
  logic             r_up;
  logic             r_oneshot;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_presc;
  logic             r_done;

  logic w_run;
  logic w_tick;
  logic w_at_target;
  logic w_match;
  logic w_finish;

  assign w_run       = (r_state == ST_RUN);
  assign w_at_target = (i_count == r_target);

  // Abort and hold both mask the tick so neither step nor match can escape
  // in the cycle they are asserted.
  assign w_tick   = w_run && !i_hold && !i_abort && (r_presc == '0);
  assign w_match  = w_tick && w_at_target;
  assign w_finish = w_match && r_oneshot;

  // A one-shot run already sitting on its target issues no step at all.
  assign o_step      = w_tick && !(r_oneshot && w_at_target);
  assign o_match     = w_match;
  assign o_busy      = w_run;
  assign o_up        = r_up;
  assign o_done      = r_done;
  assign o_cmd_ready = (r_state == ST_IDLE) && !i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_target  <= '0;
      r_up      <= 1'b0;
      r_oneshot <= 1'b0;
      r_div     <= '0;
      r_presc   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            r_target  <= i_cmd_target;
            r_up      <= i_cmd_up;
            r_oneshot <= i_cmd_oneshot;
            r_div     <= i_cmd_div;
            r_presc   <= i_cmd_div;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
          end else if (w_finish) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
          // Prescaler value is irrelevant once the run ends: it is reloaded
          // on the next accept.
          if (w_tick) begin
            r_presc <= r_div;
          end else if (!i_hold) begin
            r_presc <= r_presc - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

  localparam int LIMIT = 6000;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_target;
  logic       cmd_up;
  logic       cmd_oneshot;
  logic [3:0] cmd_div;
  logic       hold;
  logic       abort;
  logic [7:0] count;
  logic       step;
  logic       up;
  logic       match;
  logic       busy;
  logic       done;

  counter_sequencer #(.WIDTH(8), .DIV_W(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_target (cmd_target),
    .i_cmd_up     (cmd_up),
    .i_cmd_oneshot(cmd_oneshot),
    .i_cmd_div    (cmd_div),
    .i_hold       (hold),
    .i_abort      (abort),
    .i_count      (count),
    .o_step       (step),
    .o_up         (up),
    .o_match      (match),
    .o_busy       (busy),
    .o_done       (done)
  );

  typedef struct {
    int         cyc;
    bit         stp;
    bit         mat;
    bit         dn;
    logic [7:0] cnt;
  } ev_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } chk_t;

  ev_t  exp_q[$];
  chk_t chk_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   hold_a[LIMIT+2];

  // Counter datapath model: a plain register stepped by the DUT.
  logic [7:0] cnt_r = 8'd0;
  bit         load_en = 1'b0;
  logic [7:0] load_val = 8'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (load_en)   cnt_r <= load_val;
    else if (step) cnt_r <= up ? cnt_r + 8'd1 : cnt_r - 8'd1;
  end
  assign count = cnt_r;

  // Monitor: sole owner of the check/error counters.
  always @(negedge clk) begin
    chk_t k;
    ev_t  e;
    while (chk_q.size() > 0) begin
      k = chk_q.pop_front();
      checks++;
      if (k.act != k.exp) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", k.name, k.act, k.exp, cyc);
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_output: expected step=%b match=%b done=%b at cycle %0d, got nothing",
               e.stp, e.mat, e.dn, e.cyc);
    end
    if (!rst && (step || match || done)) begin
      checks++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        errors++;
        $display("FAIL unexpected_output cycle %0d: got step=%b match=%b done=%b, expected none",
                 cyc, step, match, done);
      end else begin
        e = exp_q.pop_front();
        if (e.stp != step || e.mat != match || e.dn != done || (e.mat && count != e.cnt)) begin
          errors++;
          $display("FAIL output_event cycle %0d: got step=%b match=%b done=%b count=%0d, expected step=%b match=%b done=%b count=%0d",
                   cyc, step, match, done, count, e.stp, e.mat, e.dn, e.cnt);
        end
      end
    end
  end

  task automatic post(input string n, input int a, input int x);
    chk_q.push_back('{name: n, act: a, exp: x});
  endtask

  // One command from acceptance to the first cycle after the run ends.
  // hmode: 0 no hold, 1 hold window [hs, hs+hlen), 2 random hold.
  // abort_at / rst_at: run-relative cycle (1 = first busy cycle), 0 = none.
  task automatic run_cmd(input logic [7:0] start, input logic [7:0] tgt,
                         input bit dir_up, input bit os, input logic [3:0] div,
                         input int hmode, input int hs, input int hlen,
                         input int abort_at, input int rst_at);
    int         t0;
    int         end_c;
    int         ab;
    int         since;
    logic [7:0] m_cnt;
    ab = (abort_at == 0) ? LIMIT : abort_at;
    for (int c = 0; c <= LIMIT + 1; c++) begin
      if (hmode == 1)      hold_a[c] = (c >= hs) && (c < hs + hlen);
      else if (hmode == 2) hold_a[c] = ($urandom_range(0, 7) == 0);
      else                 hold_a[c] = 1'b0;
    end
    t0 = cyc;

    // Reference: a tick happens once div+1 un-held cycles have elapsed since
    // the run began or since the previous tick.
    m_cnt = start;
    since = 0;
    end_c = LIMIT;
    for (int c = 1; c <= LIMIT; c++) begin
      if (c == rst_at || c == ab) begin
        end_c = c;
        break;
      end
      if (hold_a[c]) continue;
      if (since == int'(div)) begin
        since = 0;
        if (os && m_cnt == tgt) begin
          exp_q.push_back('{cyc: t0 + c, stp: 1'b0, mat: 1'b1, dn: 1'b0, cnt: m_cnt});
          exp_q.push_back('{cyc: t0 + c + 1, stp: 1'b0, mat: 1'b0, dn: 1'b1, cnt: m_cnt});
          end_c = c;
          break;
        end
        exp_q.push_back('{cyc: t0 + c, stp: 1'b1, mat: (m_cnt == tgt), dn: 1'b0, cnt: m_cnt});
        m_cnt = dir_up ? m_cnt + 8'd1 : m_cnt - 8'd1;
      end else begin
        since++;
      end
    end

    cmd_valid   = 1'b1;
    cmd_target  = tgt;
    cmd_up      = dir_up;
    cmd_oneshot = os;
    cmd_div     = div;
    load_en     = 1'b1;
    load_val    = start;
    post("ready_at_accept", int'(cmd_ready), 1);

    for (int c = 1; c <= end_c; c++) begin
      @(posedge clk);
      #1;
      load_en = 1'b0;
      cmd_valid = (c == 1);
      if (c == 1) begin
        cmd_target  = 8'($urandom);
        cmd_up      = 1'($urandom);
        cmd_oneshot = 1'($urandom);
        cmd_div     = 4'($urandom);
      end
      hold  = hold_a[c];
      abort = (c == ab);
      rst   = (c == rst_at);
      if (c == 1) begin
        post("busy_at_start", int'(busy), 1);
        post("ready_in_run", int'(cmd_ready), 0);
      end
    end

    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    hold      = 1'b0;
    abort     = 1'b0;
    rst       = 1'b0;
    #1;
    post("busy_after_end", int'(busy), 0);
    post("ready_after_end", int'(cmd_ready), 1);
    if (rst_at != 0 && rst_at == end_c) begin
      post("up_after_rst", int'(up), 0);
      post("step_after_rst", int'(step), 0);
      post("match_after_rst", int'(match), 0);
      post("done_after_rst", int'(done), 0);
    end else begin
      post("up_held", int'(up), int'(dir_up));
    end
  endtask

  initial begin
    logic [7:0] s, t;
    bit         u, o;
    logic [3:0] d;
    int         hm, ab, rs;

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_target = '0; cmd_up = 1'b0; cmd_oneshot = 1'b0; cmd_div = '0;
    hold = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    post("ready_in_rst", int'(cmd_ready), 0);
    post("step_in_rst", int'(step), 0);
    post("match_in_rst", int'(match), 0);
    post("busy_in_rst", int'(busy), 0);
    post("done_in_rst", int'(done), 0);
    post("up_in_rst", int'(up), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    post("ready_after_rst", int'(cmd_ready), 1);

    // One-shot up, div 0: steps 1-5, match 6, done 7.
    run_cmd(8'd0, 8'd5, 1'b1, 1'b1, 4'd0, 0, 0, 0, 0, 0);
    // One-shot, div 3: steps 4 and 8, match 12, done 13; next accepted at 13.
    run_cmd(8'd0, 8'd2, 1'b1, 1'b1, 4'd3, 0, 0, 0, 0, 0);
    // Already at target: match at cycle 1, done at 2.
    run_cmd(8'd9, 8'd9, 1'b1, 1'b1, 4'd0, 0, 0, 0, 0, 0);
    // Down count 3 -> 0.
    run_cmd(8'd3, 8'd0, 1'b0, 1'b1, 4'd0, 0, 0, 0, 0, 0);
    // Repeat through wrap: matches at 3 and 259, abort at 260.
    run_cmd(8'd254, 8'd0, 1'b1, 1'b0, 4'd0, 0, 0, 0, 260, 0);
    // Four-cycle hold mid-run.
    run_cmd(8'd0, 8'd5, 1'b1, 1'b1, 4'd1, 1, 3, 4, 0, 0);
    // Abort on the match cycle.
    run_cmd(8'd0, 8'd3, 1'b1, 1'b1, 4'd0, 0, 0, 0, 4, 0);
    // Reset mid-run.
    run_cmd(8'd10, 8'd50, 1'b1, 1'b1, 4'd0, 0, 0, 0, 0, 7);

    for (int unsigned i = 0; i < 20; i++) begin
      s  = 8'($urandom);
      t  = 8'($urandom);
      u  = 1'($urandom);
      o  = ($urandom_range(0, 3) != 0);
      d  = 4'($urandom_range(0, 7));
      hm = ($urandom_range(0, 1) == 1) ? 2 : 0;
      if (o) ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 200)) : 0;
      else   ab = int'($urandom_range(1, 600));
      rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 100)) : 0;
      run_cmd(s, t, u, o, d, hm, 0, 0, ab, rs);
    end

    repeat (5) @(posedge clk);
    #1;
    post("scoreboard_drained", exp_q.size(), 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
